rom_download_ctrl: RTL and testbench

Sequences the MiSTer ioctl ROM download stream into the four 64 KiB program EPROM banks (h0, l0, h1, l1), one byte at a time, through a write port that can stall.
- Decodes the bank from the linear download address.
- Buffers one byte and back-pressures the host with ioctl_wait.
- Holds the CPU in reset for the whole load, then releases it.
- Reports a byte count, a 16-bit checksum and sticky error flags for the on-screen loader status.

---
 rtl/rom_load_pkg.sv | 18 +
 rtl/rom_wr_buffer.sv | 40 ++++
 rtl/rom_download_ctrl.sv | 132 +++++++++++++
 tb/tb_rom_download_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download sequencer.
package rom_load_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } load_state_t;

    localparam int unsigned ROM_BYTES = 32'h0004_0000;

    localparam int unsigned BANK_H0 = 0;
    localparam int unsigned BANK_L0 = 1;
    localparam int unsigned BANK_H1 = 2;
    localparam int unsigned BANK_L1 = 3;

endpackage

// File: rtl/rom_wr_buffer.sv
// Single-entry holding register between the ioctl byte stream and the EPROM write port.
module rom_wr_buffer #(
    parameter int unsigned CS_W = 4,
    parameter int unsigned AW   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic [CS_W-1:0] push_cs,
    input  logic [AW-1:0]   push_addr,
    input  logic [7:0]      push_data,
    input  logic            ready,
    output logic            full,
    output logic            pop,
    output logic [CS_W-1:0] out_cs,
    output logic [AW-1:0]   out_addr,
    output logic [7:0]      out_data
);

    assign pop = full & ready;

    // A push in the same cycle as a pop reloads the entry, so the slot never goes empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full     <= 1'b0;
            out_cs   <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else if (push) begin
            full     <= 1'b1;
            out_cs   <= push_cs;
            out_addr <= push_addr;
            out_data <= push_data;
        end else if (pop) begin
            full   <= 1'b0;
            out_cs <= '0;
        end
    end

endmodule

// File: rtl/rom_download_ctrl.sv
// Sequences the MiSTer ioctl ROM download into the program EPROM banks and
// holds the CPU in reset until the load has drained.
module rom_download_ctrl
    import rom_load_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned BANK_AW     = 16,
    parameter int unsigned RELEASE_DLY = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    output logic [BANK_AW-1:0]   mem_addr,
    output logic [7:0]           mem_data,
    output logic [NUM_BANKS-1:0] mem_cs,
    output logic                 mem_wr,
    input  logic                 mem_ready,
    output logic                 cpu_reset_hold,
    output logic                 load_done,
    output logic [18:0]          byte_count,
    output logic [15:0]          checksum,
    output logic                 range_err,
    output logic                 overrun_err
);

    localparam int unsigned BANK_BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [25:0] ADDR_LIMIT = 26'(NUM_BANKS) << BANK_AW;

    load_state_t state, state_next;
    logic               dl_q;
    logic               dl_rise, dl_fall;
    logic               enter_load;
    logic               in_range, wr_load, push, full, pop;
    logic [BANK_BW-1:0] bank_idx;
    logic [NUM_BANKS-1:0] push_cs;
    logic [7:0]         rel_cnt;

    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign in_range   = {1'b0, ioctl_addr} < ADDR_LIMIT;
    assign wr_load    = (state == LOAD) && ioctl_wr;
    assign push       = wr_load && in_range && (!full || pop);
    assign bank_idx   = ioctl_addr[BANK_AW +: BANK_BW];
    assign enter_load = (state != LOAD) && (state_next == LOAD);

    always_comb begin
        push_cs           = '0;
        push_cs[bank_idx] = 1'b1;
    end

    rom_wr_buffer #(
        .CS_W (NUM_BANKS),
        .AW   (BANK_AW)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_cs   (push_cs),
        .push_addr (ioctl_addr[BANK_AW-1:0]),
        .push_data (ioctl_dout),
        .ready     (mem_ready),
        .full      (full),
        .pop       (pop),
        .out_cs    (mem_cs),
        .out_addr  (mem_addr),
        .out_data  (mem_data)
    );

    assign mem_wr     = full;
    assign ioctl_wait = full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dl_q  <= 1'b0;
        end else begin
            state <= state_next;
            dl_q  <= ioctl_download;
        end
    end

    // DRAIN leaves as soon as the last write is accepted, not a cycle later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dl_rise) state_next = LOAD;
            LOAD:    if (dl_fall) state_next = DRAIN;
            DRAIN:   if (!full || pop) state_next = DONE;
            DONE:    if (dl_rise) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rel_cnt <= '0;
        end else if (state != DONE) begin
            rel_cnt <= '0;
        end else if (rel_cnt != 8'(RELEASE_DLY)) begin
            rel_cnt <= rel_cnt + 8'd1;
        end
    end

    assign load_done      = (state == DONE);
    assign cpu_reset_hold = !((state == DONE) && (rel_cnt == 8'(RELEASE_DLY)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_count  <= '0;
            checksum    <= '0;
            range_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (enter_load) begin
            byte_count  <= '0;
            checksum    <= '0;
            range_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (pop) begin
                if (byte_count != 19'(ROM_BYTES)) byte_count <= byte_count + 19'd1;
                checksum <= checksum + {8'h00, mem_data};
            end
            if (wr_load && !in_range) range_err <= 1'b1;
            if (wr_load && in_range && full && !pop) overrun_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed self-checking bench for rom_download_ctrl.
module tb_rom_download_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [3:0]  mem_cs;
    logic        mem_wr;
    logic        mem_ready;
    logic        cpu_reset_hold;
    logic        load_done;
    logic [18:0] byte_count;
    logic [15:0] checksum;
    logic        range_err;
    logic        overrun_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rom_download_ctrl #(
        .NUM_BANKS   (4),
        .BANK_AW     (16),
        .RELEASE_DLY (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_cs         (mem_cs),
        .mem_wr         (mem_wr),
        .mem_ready      (mem_ready),
        .cpu_reset_hold (cpu_reset_hold),
        .load_done      (load_done),
        .byte_count     (byte_count),
        .checksum       (checksum),
        .range_err      (range_err),
        .overrun_err    (overrun_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        mem_ready      = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({ioctl_wait, mem_wr, mem_cs, mem_addr, mem_data} !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got %h, expected 0", {ioctl_wait, mem_wr, mem_cs, mem_addr, mem_data});
        end
        n_checks++;
        if ({cpu_reset_hold, load_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_hold: got %b, expected 10", {cpu_reset_hold, load_done});
        end
        n_checks++;
        if ({byte_count, checksum, range_err, overrun_err} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h, expected 0", {byte_count, checksum, range_err, overrun_err});
        end
        reset_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({cpu_reset_hold, load_done, mem_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b, expected 100", {cpu_reset_hold, load_done, mem_wr});
        end
    endtask

    task automatic test_basic();
        int n;
        mem_ready = 1'b1;
        start_dl();
        n_checks++;
        if ({cpu_reset_hold, load_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_load_entry: got %b, expected 10", {cpu_reset_hold, load_done});
        end
        wr_byte(25'h0000000, 8'h01);
        n_checks++;
        if ({mem_wr, ioctl_wait, mem_cs, mem_addr, mem_data} !== {1'b1, 1'b1, 4'b0001, 16'h0000, 8'h01}) begin
            n_fail++;
            $display("FAIL basic_b0: got %h, expected %h", {mem_wr, ioctl_wait, mem_cs, mem_addr, mem_data},
                     {1'b1, 1'b1, 4'b0001, 16'h0000, 8'h01});
        end
        wr_byte(25'h0010000, 8'h02);
        n_checks++;
        if ({mem_wr, mem_cs, mem_addr, mem_data} !== {1'b1, 4'b0010, 16'h0000, 8'h02}) begin
            n_fail++;
            $display("FAIL basic_b1: got %h, expected %h", {mem_wr, mem_cs, mem_addr, mem_data},
                     {1'b1, 4'b0010, 16'h0000, 8'h02});
        end
        wr_byte(25'h003FFFF, 8'h03);
        n_checks++;
        if ({mem_wr, mem_cs, mem_addr, mem_data} !== {1'b1, 4'b1000, 16'hFFFF, 8'h03}) begin
            n_fail++;
            $display("FAIL basic_b3: got %h, expected %h", {mem_wr, mem_cs, mem_addr, mem_data},
                     {1'b1, 4'b1000, 16'hFFFF, 8'h03});
        end
        ioctl_download = 1'b0;
        tick();
        n_checks++;
        if ({mem_wr, ioctl_wait, mem_cs, load_done, cpu_reset_hold} !== {1'b0, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_drained: got %b, expected 0000001", {mem_wr, ioctl_wait, mem_cs, load_done, cpu_reset_hold});
        end
        tick();
        n_checks++;
        if ({load_done, cpu_reset_hold, byte_count, checksum} !== {1'b1, 1'b1, 19'd3, 16'h0006}) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b hold=%b count=%0d sum=%h, expected 1 1 3 0006",
                     load_done, cpu_reset_hold, byte_count, checksum);
        end
        n = 0;
        while (cpu_reset_hold && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL basic_release_dly: got %0d cycles, expected 16", n);
        end
    endtask

    task automatic test_stall();
        start_dl();
        n_checks++;
        if ({cpu_reset_hold, load_done, byte_count, checksum} !== {1'b1, 1'b0, 19'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reload_entry: got hold=%b done=%b count=%0d sum=%h, expected 1 0 0 0000",
                     cpu_reset_hold, load_done, byte_count, checksum);
        end
        mem_ready = 1'b0;
        wr_byte(25'h0000123, 8'hAA);
        n_checks++;
        if ({mem_wr, ioctl_wait, mem_cs, mem_addr, mem_data} !== {1'b1, 1'b1, 4'b0001, 16'h0123, 8'hAA}) begin
            n_fail++;
            $display("FAIL stall_capture: got %h, expected %h", {mem_wr, ioctl_wait, mem_cs, mem_addr, mem_data},
                     {1'b1, 1'b1, 4'b0001, 16'h0123, 8'hAA});
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'h0000124;
                ioctl_dout = 8'h55;
            end
            tick();
            ioctl_wr = 1'b0;
            n_checks++;
            if ({ioctl_wait, mem_wr, mem_addr, mem_data} !== {1'b1, 1'b1, 16'h0123, 8'hAA}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h, expected %h", i, {ioctl_wait, mem_wr, mem_addr, mem_data},
                         {1'b1, 1'b1, 16'h0123, 8'hAA});
            end
        end
        n_checks++;
        if ({overrun_err, byte_count} !== {1'b1, 19'd0}) begin
            n_fail++;
            $display("FAIL stall_overrun: got ovr=%b count=%0d, expected 1 0", overrun_err, byte_count);
        end
        mem_ready = 1'b1;
        tick();
        n_checks++;
        if ({mem_wr, ioctl_wait, mem_cs, byte_count, checksum} !== {1'b0, 1'b0, 4'b0000, 19'd1, 16'h00AA}) begin
            n_fail++;
            $display("FAIL stall_release: got wr=%b wait=%b cs=%b count=%0d sum=%h, expected 0 0 0000 1 00aa",
                     mem_wr, ioctl_wait, mem_cs, byte_count, checksum);
        end
    endtask

    task automatic test_range();
        wr_byte(25'h0040000, 8'h77);
        n_checks++;
        if ({range_err, mem_wr, mem_cs} !== {1'b1, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL range_flag: got err=%b wr=%b cs=%b, expected 1 0 0000", range_err, mem_wr, mem_cs);
        end
        tick();
        n_checks++;
        if ({byte_count, checksum, mem_wr} !== {19'd1, 16'h00AA, 1'b0}) begin
            n_fail++;
            $display("FAIL range_count: got count=%0d sum=%h wr=%b, expected 1 00aa 0", byte_count, checksum, mem_wr);
        end
    endtask

    task automatic test_drain();
        mem_ready = 1'b0;
        wr_byte(25'h0020005, 8'h10);
        n_checks++;
        if ({mem_wr, mem_cs, mem_addr} !== {1'b1, 4'b0100, 16'h0005}) begin
            n_fail++;
            $display("FAIL drain_capture: got wr=%b cs=%b addr=%h, expected 1 0100 0005", mem_wr, mem_cs, mem_addr);
        end
        ioctl_download = 1'b0;
        repeat (2) begin
            tick();
            n_checks++;
            if ({load_done, mem_wr, cpu_reset_hold} !== 3'b011) begin
                n_fail++;
                $display("FAIL drain_pending: got %b, expected 011", {load_done, mem_wr, cpu_reset_hold});
            end
        end
        mem_ready = 1'b1;
        tick();
        n_checks++;
        if ({load_done, mem_wr, byte_count, checksum} !== {1'b1, 1'b0, 19'd2, 16'h00BA}) begin
            n_fail++;
            $display("FAIL drain_done: got done=%b wr=%b count=%0d sum=%h, expected 1 0 2 00ba",
                     load_done, mem_wr, byte_count, checksum);
        end
        n_checks++;
        if ({range_err, overrun_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL drain_sticky: got %b, expected 11", {range_err, overrun_err});
        end
    endtask

    task automatic test_checksum_wrap();
        start_dl();
        n_checks++;
        if ({range_err, overrun_err, byte_count, checksum} !== 37'h0) begin
            n_fail++;
            $display("FAIL wrap_entry_clear: got %h, expected 0", {range_err, overrun_err, byte_count, checksum});
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 300; i++) wr_byte(25'(i), 8'hFF);
        ioctl_download = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({byte_count, checksum, load_done} !== {19'd300, 16'h2AD4, 1'b1}) begin
            n_fail++;
            $display("FAIL checksum_wrap: got count=%0d sum=%h done=%b, expected 300 2ad4 1",
                     byte_count, checksum, load_done);
        end
    endtask

    task automatic test_reset_midload();
        start_dl();
        mem_ready = 1'b0;
        wr_byte(25'h0010010, 8'h5A);
        n_checks++;
        if ({mem_wr, mem_cs} !== {1'b1, 4'b0010}) begin
            n_fail++;
            $display("FAIL midload_pending: got wr=%b cs=%b, expected 1 0010", mem_wr, mem_cs);
        end
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        #2;
        n_checks++;
        if ({ioctl_wait, mem_wr, mem_cs, mem_addr, mem_data} !== 30'h0) begin
            n_fail++;
            $display("FAIL midload_reset_mem: got %h, expected 0", {ioctl_wait, mem_wr, mem_cs, mem_addr, mem_data});
        end
        n_checks++;
        if ({cpu_reset_hold, load_done, byte_count, checksum, range_err, overrun_err} !== {2'b10, 37'h0}) begin
            n_fail++;
            $display("FAIL midload_reset_stats: got %h, expected %h",
                     {cpu_reset_hold, load_done, byte_count, checksum, range_err, overrun_err}, {2'b10, 37'h0});
        end
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({cpu_reset_hold, load_done, mem_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL midload_idle: got %b, expected 100", {cpu_reset_hold, load_done, mem_wr});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_range();
        test_drain();
        test_checksum_wrap();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
